strobe_event_encoder: RTL

- Sits downstream of the combinational control decoder and consumes its 21 decoded strobe outputs, in order p0..j1, as bits 0..20.
- Detects each strobe's rising edge and records it as pending.
- Emits one 5-bit event code per pending strobe over a valid/ready stream to the sequencing controller.
- The decoder maps control inputs to strobes; this block turns strobe activity back into an ordered event stream.

---
 rtl/strb_pkg.sv | 40 ++++
 rtl/strb_prio_enc.sv | 25 ++
 rtl/strobe_event_encoder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/strb_pkg.sv
// Shared types and constants for the strobe event encoder: strobe indices, code width
// and output-stage state encoding.
package strb_pkg;

    localparam int unsigned NUM_STRB_DEF = 21;
    localparam int unsigned CODE_W_DEF   = 5;
    localparam int unsigned TS_W         = 16;

    typedef logic [NUM_STRB_DEF-1:0] strb_vec_t;
    typedef logic [CODE_W_DEF-1:0]   evt_code_t;

    // Bit positions of the decoder strobes, p0 first and j1 last.
    localparam int unsigned P0_IDX = 0;
    localparam int unsigned P1_IDX = 1;
    localparam int unsigned P2_IDX = 2;
    localparam int unsigned P3_IDX = 3;
    localparam int unsigned Q0_IDX = 4;
    localparam int unsigned Q1_IDX = 5;
    localparam int unsigned Q2_IDX = 6;
    localparam int unsigned Q3_IDX = 7;
    localparam int unsigned R0_IDX = 8;
    localparam int unsigned R1_IDX = 9;
    localparam int unsigned R2_IDX = 10;
    localparam int unsigned R3_IDX = 11;
    localparam int unsigned S0_IDX = 12;
    localparam int unsigned S1_IDX = 13;
    localparam int unsigned S2_IDX = 14;
    localparam int unsigned S3_IDX = 15;
    localparam int unsigned T0_IDX = 16;
    localparam int unsigned T1_IDX = 17;
    localparam int unsigned T2_IDX = 18;
    localparam int unsigned J0_IDX = 19;
    localparam int unsigned J1_IDX = 20;

    typedef enum logic {
        IDLE,
        OUT
    } out_state_e;

endpackage

// File: rtl/strb_prio_enc.sv
// Lowest-set-bit priority encoder over the pending strobe mask.
module strb_prio_enc
    import strb_pkg::*;
#(
    parameter int unsigned NUM_STRB = NUM_STRB_DEF,
    parameter int unsigned CODE_W   = CODE_W_DEF
) (
    input  logic [NUM_STRB-1:0] vec,
    output logic                found,
    output logic [CODE_W-1:0]   idx
);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = int'(NUM_STRB) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                found = 1'b1;
                idx   = CODE_W'(i);
            end
        end
    end

endmodule

// File: rtl/strobe_event_encoder.sv
// Turns rising edges on decoded strobes into an ordered valid/ready stream of event codes.
// Optional STRB_TIMESTAMP_EN adds a cycle counter and per-event timestamp output evt_ts.
module strobe_event_encoder
    import strb_pkg::*;
#(
    parameter int unsigned NUM_STRB = NUM_STRB_DEF,
    parameter int unsigned CODE_W   = CODE_W_DEF,
    parameter int unsigned OVF_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_STRB-1:0] strb_in,
    input  logic                enable,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [CODE_W-1:0]   evt_code,
    output logic [NUM_STRB-1:0] pending,
    output logic [OVF_W-1:0]    ovf_cnt,
    output logic                busy
`ifdef STRB_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0]     evt_ts
`endif
);

    localparam int unsigned SUM_W = OVF_W + 6;

    logic [NUM_STRB-1:0] strb_q;
    logic [NUM_STRB-1:0] pending_q, pending_d;
    logic [NUM_STRB-1:0] rise;
    logic [NUM_STRB-1:0] clr;
    logic [NUM_STRB-1:0] ovf_bits;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [OVF_W-1:0]    ovf_q, ovf_d;
    logic [5:0]          ovf_inc;
    logic [SUM_W-1:0]    ovf_sum;
    out_state_e          state_q, state_d;
    logic                load;
    logic                enc_found;
    logic [CODE_W-1:0]   enc_idx;

    strb_prio_enc #(
        .NUM_STRB (NUM_STRB),
        .CODE_W   (CODE_W)
    ) u_prio_enc (
        .vec   (pending_q),
        .found (enc_found),
        .idx   (enc_idx)
    );

    always_comb begin
        rise    = strb_in & ~strb_q & {NUM_STRB{enable}};
        load    = (state_q == IDLE) || evt_ready;
        clr     = '0;
        state_d = state_q;
        code_d  = code_q;

        // The encoder sees only the registered mask; this cycle's rises wait one cycle.
        if (load) begin
            if (enc_found) begin
                state_d = OUT;
                code_d  = enc_idx;
                clr     = NUM_STRB'(1) << enc_idx;
            end else begin
                state_d = IDLE;
            end
        end

        // A bit being handed to the output register this cycle re-pends rather than overflows.
        ovf_bits  = rise & pending_q & ~clr;
        pending_d = (pending_q & ~clr) | rise;

        ovf_inc = '0;
        for (int i = 0; i < int'(NUM_STRB); i++) begin
            ovf_inc = ovf_inc + 6'(ovf_bits[i]);
        end
        ovf_sum = SUM_W'(ovf_q) + SUM_W'(ovf_inc);
        if (ovf_sum > SUM_W'({OVF_W{1'b1}})) begin
            ovf_d = '1;
        end else begin
            ovf_d = OVF_W'(ovf_sum);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            strb_q    <= '0;
            pending_q <= '0;
            code_q    <= '0;
            ovf_q     <= '0;
            state_q   <= IDLE;
        end else begin
            strb_q    <= strb_in;
            pending_q <= pending_d;
            code_q    <= code_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
        end
    end

`ifdef STRB_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt_q;
    logic [TS_W-1:0] ts_mem_q [NUM_STRB];
    logic [TS_W-1:0] evt_ts_q;

    // An overflowed re-rise keeps the timestamp of the edge that is still pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            ts_cnt_q <= '0;
            evt_ts_q <= '0;
            for (int i = 0; i < int'(NUM_STRB); i++) begin
                ts_mem_q[i] <= '0;
            end
        end else begin
            ts_cnt_q <= ts_cnt_q + 1'b1;
            for (int i = 0; i < int'(NUM_STRB); i++) begin
                if (rise[i] && !ovf_bits[i]) begin
                    ts_mem_q[i] <= ts_cnt_q;
                end
            end
            if (load && enc_found) begin
                evt_ts_q <= ts_mem_q[enc_idx];
            end
        end
    end

    assign evt_ts = evt_ts_q;
`endif

    assign evt_valid = (state_q == OUT);
    assign evt_code  = code_q;
    assign pending   = pending_q;
    assign ovf_cnt   = ovf_q;
    assign busy      = (|pending_q) || (state_q == OUT);

endmodule
